// File: rtl/prco_fetch_pkg.sv
// prco_fetch_pkg: shared state encoding and default parameters for the fetch unit.
package prco_fetch_pkg;
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_BUSY = 2'd1,
      S_WAIT = 2'd2,
      S_HALT = 2'd3
   } fetch_state_e;
   localparam int unsigned PRCO_ADDR_W   = 8;
   localparam int unsigned PRCO_INSTR_W  = 16;
   localparam int unsigned PRCO_RESET_PC = 0;
endpackage

// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch FSM and PC register feeding prco_decoder,
// one outstanding memory read at a time, with redirect and halt handling.
module prco_fetch
   import prco_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = PRCO_ADDR_W,
   parameter int unsigned INSTR_W  = PRCO_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PRCO_RESET_PC)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_en,
   input  logic               i_fetch,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   input  logic               i_halt,
   output logic               q_imem_req,
   output logic [ADDR_W-1:0]  q_imem_addr,
   input  logic               i_imem_ack,
   input  logic [INSTR_W-1:0] i_imem_data,
   output logic               q_ce,
   output logic [INSTR_W-1:0] q_instr,
   output logic [ADDR_W-1:0]  q_pc,
   output logic               q_halted
);
   fetch_state_e       r_state, w_next;
   logic [ADDR_W-1:0]  r_pc, r_addr, r_qpc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_drop, r_halt_pend, r_ce;
   logic               w_redir, w_issue, w_deliver, w_busy_wait;

   // halt outranks redirect, and nothing moves the PC once halted
   assign w_redir     = i_redirect & ~i_halt & (r_state != S_HALT);
   assign w_issue     = (r_state == S_REQ) & (w_next == S_BUSY);
   assign w_deliver   = (r_state == S_BUSY) & (w_next == S_WAIT);
   assign w_busy_wait = (r_state == S_BUSY) & ~i_imem_ack;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_REQ;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_REQ:   w_next = i_halt ? S_HALT : (i_en & ~i_redirect) ? S_BUSY : S_REQ;
         S_BUSY:  w_next = ~i_imem_ack ? S_BUSY :
                           (r_halt_pend | i_halt) ? S_HALT :
                           (r_drop | i_redirect) ? S_REQ : S_WAIT;
         S_WAIT:  w_next = i_halt ? S_HALT : (i_fetch | i_redirect) ? S_REQ : S_WAIT;
         default: w_next = S_HALT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pc        <= RESET_PC;
         r_addr      <= RESET_PC;
         r_qpc       <= '0;
         r_instr     <= '0;
         r_ce        <= 1'b0;
         r_drop      <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_pc        <= w_redir ? i_redirect_pc : w_deliver ? r_addr + 1'b1 : r_pc;
         r_addr      <= w_issue ? r_pc : r_addr;
         r_qpc       <= w_deliver ? r_addr : r_qpc;
         r_instr     <= w_deliver ? i_imem_data : r_instr;
         r_ce        <= w_deliver;
         r_drop      <= w_busy_wait & (r_drop | w_redir);
         r_halt_pend <= w_busy_wait & (r_halt_pend | i_halt);
      end
   end

   always_comb begin
      q_imem_req  = (r_state == S_BUSY);
      q_imem_addr = r_addr;
      q_ce        = r_ce;
      q_instr     = r_instr;
      q_pc        = r_qpc;
      q_halted    = (r_state == S_HALT);
   end
endmodule
